// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit for the pipelined MIPS core; sits beside
// the ID stage.
//
// It picks the source of ALU operand A, ALU operand B and the store data. Each
// one comes either from one of NUM_FWD downstream stages or from the register
// file. Stage 0 is EX (youngest) and stage NUM_FWD-1 is the oldest stage.
//
// When ID consumes the result of a load that has not yet reached a stage
// where its data can be forwarded (stage index LOAD_LAT), the unit stalls the
// PC and IF/ID and bubbles ID/EX for exactly the number of cycles needed.
//
// A saturating counter totals the stall cycles since reset.
//
// Select encoding: 0 = shamt/immediate override, k+1 = stage k,
//                  NUM_FWD+1 = register file.
//
// Ports
//   CLK           in   clock, rising edge
//   Reset_L       in   asynchronous reset, active-low
//   Flush         in   ID instruction squashed (taken branch/jump)
//   ID_Valid      in   ID holds a real instruction
//   UseShamt      in   operand A = shamt
//   UseImmed      in   operand B = sign-extended immediate
//   ID_UsesRs     in   ID instruction reads Rs
//   ID_UsesRt     in   ID instruction reads Rt
//   ID_Rs, ID_Rt  in   source register specifiers
//   Fwd_Rw        in   dest reg of stage k at [k*REG_ADDR_W +: REG_ADDR_W]
//   Fwd_RegWrite  in   stage k writes its dest reg
//   Fwd_MemRead   in   stage k is a load
//   AluSelA/B     out  ALU operand source selects
//   StoreFwdSel   out  store-data source select (no immediate override)
//   Stall         out  hold PC and IF/ID this cycle
//   Bubble        out  zero ID/EX control this cycle (equals Stall)
//   StallCount    out  saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_FWD    = 3,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 16
) (
    input  logic                          CLK,
    input  logic                          Reset_L,
    input  logic                          Flush,
    input  logic                          ID_Valid,
    input  logic                          UseShamt,
    input  logic                          UseImmed,
    input  logic                          ID_UsesRs,
    input  logic                          ID_UsesRt,
    input  logic [REG_ADDR_W-1:0]         ID_Rs,
    input  logic [REG_ADDR_W-1:0]         ID_Rt,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] Fwd_Rw,
    input  logic [NUM_FWD-1:0]            Fwd_RegWrite,
    input  logic [NUM_FWD-1:0]            Fwd_MemRead,
    output logic [SEL_W-1:0]              AluSelA,
    output logic [SEL_W-1:0]              AluSelB,
    output logic [SEL_W-1:0]              StoreFwdSel,
    output logic                          Stall,
    output logic                          Bubble,
    output logic [CNT_W-1:0]              StallCount
);

    localparam logic [SEL_W-1:0] SEL_OVR = '0;
    localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(NUM_FWD + 1);
    // Wide enough for the largest stall length (LOAD_LAT <= NUM_FWD-1).
    localparam int WAIT_W = (NUM_FWD > 1) ? $clog2(NUM_FWD + 1) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // Per-stage match terms
    // ---------------------------------------------------------------------
    logic [NUM_FWD-1:0] elig_rs;
    logic [NUM_FWD-1:0] elig_rt;
    logic [NUM_FWD-1:0] haz_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FWD; gi++) begin : g_stage
            logic [REG_ADDR_W-1:0] rw;
            logic                  can_fwd;

            assign rw = Fwd_Rw[gi*REG_ADDR_W +: REG_ADDR_W];

            // A load that is still younger than LOAD_LAT has no data yet,
            // so it must not be selected as a forwarding source.
            if (gi < LOAD_LAT) begin : g_early
                assign can_fwd = Fwd_RegWrite[gi] && (rw != '0) && !Fwd_MemRead[gi];
                // Shamt-type instructions take operand A from the
                // instruction word, so a load into Rs does not stall them.
                assign haz_hit[gi] = Fwd_MemRead[gi] && Fwd_RegWrite[gi] && (rw != '0) &&
                                     ((ID_UsesRs && !UseShamt && (rw == ID_Rs)) ||
                                      (ID_UsesRt && (rw == ID_Rt)));
            end else begin : g_late
                assign can_fwd     = Fwd_RegWrite[gi] && (rw != '0);
                assign haz_hit[gi] = 1'b0;
            end

            assign elig_rs[gi] = can_fwd && (rw == ID_Rs);
            assign elig_rt[gi] = can_fwd && (rw == ID_Rt);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Priority: the youngest matching stage wins. Scanning from oldest to
    // youngest lets the last assignment hold the youngest hit.
    // ---------------------------------------------------------------------
    logic [SEL_W-1:0]  sel_rs;
    logic [SEL_W-1:0]  sel_rt;
    logic [WAIT_W-1:0] need;
    logic              hazard;

    always_comb begin
        sel_rs = SEL_RF;
        sel_rt = SEL_RF;
        need   = '0;
        hazard = ID_Valid && (|haz_hit);
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (elig_rs[k]) sel_rs = SEL_W'(k + 1);
            if (elig_rt[k]) sel_rt = SEL_W'(k + 1);
            if (haz_hit[k]) need   = WAIT_W'(LOAD_LAT - k);
        end
    end

    // ---------------------------------------------------------------------
    // Stall FSM. The first stall cycle is issued from IDLE; ST_STALL covers
    // the remaining need-1 cycles, so wait_q counts the cycles still owed.
    // ---------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              stall_fsm;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        stall_fsm = 1'b0;
        if (Flush) begin
            // The squashed instruction no longer needs its operands.
            state_d = ST_IDLE;
            wait_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hazard) begin
                        stall_fsm = 1'b1;
                        if (need > WAIT_W'(1)) begin
                            state_d = ST_STALL;
                            wait_d  = need - WAIT_W'(1);
                        end
                    end
                end
                ST_STALL: begin
                    stall_fsm = 1'b1;
                    if (wait_q == WAIT_W'(1)) begin
                        state_d = ST_IDLE;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: forced to safe values while reset is asserted so that the
    // rest of the pipeline never sees a stall or a forwarded value then.
    // ---------------------------------------------------------------------
    assign Stall       = Reset_L && stall_fsm;
    assign Bubble      = Stall;
    assign AluSelA     = !Reset_L ? SEL_RF : (UseShamt ? SEL_OVR : sel_rs);
    assign AluSelB     = !Reset_L ? SEL_RF : (UseImmed ? SEL_OVR : sel_rt);
    assign StoreFwdSel = !Reset_L ? SEL_RF : sel_rt;

    // ---------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            stall_cnt_q <= '0;
        end else if (Stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt_q;

endmodule
